// File: rtl/mlbmp_pkg.sv
// mlbmp_pkg: shared screen geometry, op encodings and plotter states
package mlbmp_pkg;
  localparam int SCR_W_DEF = 320;
  localparam int SCR_H_DEF = 240;
  function automatic int bytes_per_row(input int w);
    return w / 8;
  endfunction
  localparam int BYTES_PER_ROW = bytes_per_row(SCR_W_DEF);
  typedef enum logic [1:0] {OP_CLR = 2'b00, OP_SET = 2'b01, OP_XOR = 2'b10, OP_FILL = 2'b11} op_t;
  typedef enum logic [2:0] {IDLE, RD, WR, FILL, ERR} state_t;
endpackage

// File: rtl/mlbmp_plot_if.sv
// mlbmp_plot_if: command handshake and screen memory bus (master issues commands and serves memory; slave is the plotter)
interface mlbmp_plot_if;
  logic req;
  logic [1:0] op;
  logic [8:0] x;
  logic [7:0] y;
  logic color;
  logic ready;
  logic done;
  logic err;
  logic [15:0] mem_addr;
  logic mem_re;
  logic [7:0] mem_rdata;
  logic mem_we;
  logic [7:0] mem_wdata;
  modport master (output req, op, x, y, color, mem_rdata, input ready, done, err, mem_addr, mem_re, mem_we, mem_wdata);
  modport slave (input req, op, x, y, color, mem_rdata, output ready, done, err, mem_addr, mem_re, mem_we, mem_wdata);
endinterface

// File: rtl/mlbmp_addr.sv
// mlbmp_addr: pixel (x,y) to screen byte address {y,2'b00,x[8:3]} and bit index x[2:0] (bit 0 = leftmost)
module mlbmp_addr (
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] addr,
  output logic [2:0]  bit_idx
);
  assign addr = {y, 2'b00, x[8:3]};
  assign bit_idx = x[2:0];
endmodule

// File: rtl/mlbmp_plot.sv
// mlbmp_plot: 1bpp pixel plotter (clear/set/xor via read-modify-write, fill screen); clk, async rst_n, bus = mlbmp_plot_if.slave; xor enabled by MLBMP_PLOT_XOR_EN
module mlbmp_plot
  import mlbmp_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input logic         clk,
  input logic         rst_n,
  mlbmp_plot_if.slave bus
);
  localparam logic [8:0] w_lim = 9'(SCR_W);
  localparam logic [7:0] h_lim = 8'(SCR_H);
  localparam logic [5:0] last_col = 6'(bytes_per_row(SCR_W) - 1);
  localparam logic [7:0] last_row = 8'(SCR_H - 1);
  state_t state, state_nx;
  op_t op_q, op_in;
  logic [8:0] x_q;
  logic [7:0] y_q, row;
  logic [5:0] col;
  logic color_q, accept, bad, fill_last;
  logic [15:0] pix_addr;
  logic [2:0] pix_bit;
  logic [7:0] mask, pix_data;
  mlbmp_addr u_addr (.x(x_q), .y(y_q), .addr(pix_addr), .bit_idx(pix_bit));
  assign op_in = op_t'(bus.op);
  assign accept = bus.req && state == IDLE;
  assign fill_last = row == last_row && col == last_col;
  assign mask = 8'b1 << pix_bit;
`ifdef MLBMP_PLOT_XOR_EN
  assign bad = op_in != OP_FILL && (bus.x >= w_lim || bus.y >= h_lim);
  assign pix_data = op_q == OP_CLR ? bus.mem_rdata & ~mask
                  : op_q == OP_XOR ? bus.mem_rdata ^ mask
                  : bus.mem_rdata | mask;
`else
  assign bad = op_in == OP_XOR || (op_in != OP_FILL && (bus.x >= w_lim || bus.y >= h_lim));
  assign pix_data = op_q == OP_CLR ? bus.mem_rdata & ~mask : bus.mem_rdata | mask;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept ? (bad ? ERR : op_in == OP_FILL ? FILL : RD) : IDLE)
             : state == RD ? WR
             : state == FILL && !fill_last ? FILL
             : IDLE;
  end
  // row/col walk the screen during FILL; the wrap past the last byte is harmless as the next accept rezeroes them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= OP_CLR;
      x_q <= '0;
      y_q <= '0;
      color_q <= 1'b0;
      row <= '0;
      col <= '0;
    end else if (accept) begin
      op_q <= op_in;
      x_q <= bus.x;
      y_q <= bus.y;
      color_q <= bus.color;
      row <= '0;
      col <= '0;
    end else if (state == FILL) begin
      col <= col == last_col ? '0 : col + 6'd1;
      row <= col == last_col ? row + 8'd1 : row;
    end
  always_comb begin
    bus.ready = state == IDLE;
    bus.done = state == WR || (state == FILL && fill_last);
    bus.err = state == ERR;
    bus.mem_re = state == RD;
    bus.mem_we = state == WR || state == FILL;
    bus.mem_addr = (state == RD || state == WR) ? pix_addr : state == FILL ? {row, 2'b00, col} : '0;
    bus.mem_wdata = state == WR ? pix_data : state == FILL ? {8{color_q}} : '0;
  end
endmodule

// File: tb/tb_mlbmp_plot.sv
// tb_mlbmp_plot: directed self-checking bench for mlbmp_plot
module tb_mlbmp_plot;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int checks = 0, errors = 0, conflicts = 0;
  int n_we, n_bad, n_data, n_re, n_done;
  logic [15:0] first_addr, last_addr;
  logic done_seen, done_last;
  mlbmp_plot_if bus ();
  mlbmp_plot #(.SCR_W(320), .SCR_H(240)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.mem_rdata <= bus.mem_re ? rd_val : 8'h5A;
  always @(negedge clk) if ((bus.mem_re && bus.mem_we) || (bus.done && bus.err)) conflicts++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [8:0] xi, input logic [7:0] yi, input logic c, input logic [7:0] rd);
    rd_val = rd;
    bus.op = o;
    bus.x = xi;
    bus.y = yi;
    bus.color = c;
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    bus.x = 9'h1FF;
    bus.y = 8'hFF;
  endtask
  task automatic rmw(input string tag, input logic [1:0] o, input logic [8:0] xi, input logic [7:0] yi,
                     input logic [7:0] rd, input logic [15:0] ea, input logic [7:0] ed);
    issue(o, xi, yi, 1'b0, rd);
    @(negedge clk);
    chk({tag, "_rd"}, {bus.mem_re, bus.mem_we, bus.ready, bus.done, bus.err}, 5'b10000);
    chk({tag, "_raddr"}, bus.mem_addr, ea);
    @(negedge clk);
    chk({tag, "_wr"}, {bus.mem_re, bus.mem_we, bus.ready, bus.done, bus.err}, 5'b01010);
    chk({tag, "_waddr"}, bus.mem_addr, ea);
    chk({tag, "_wdata"}, bus.mem_wdata, ed);
    @(negedge clk);
    chk({tag, "_idle"}, {bus.ready, bus.done, bus.mem_we}, 3'b100);
  endtask
  task automatic reject(input string tag, input logic [1:0] o, input logic [8:0] xi, input logic [7:0] yi);
    issue(o, xi, yi, 1'b0, 8'h00);
    @(negedge clk);
    chk({tag, "_err"}, {bus.mem_re, bus.mem_we, bus.ready, bus.done, bus.err}, 5'b00001);
    @(negedge clk);
    chk({tag, "_back"}, {bus.ready, bus.err, bus.mem_re, bus.mem_we}, 4'b1000);
  endtask
  initial begin
    bus.req = 1'b0;
    bus.op = 2'b00;
    bus.x = '0;
    bus.y = '0;
    bus.color = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {bus.ready, bus.done, bus.err, bus.mem_re, bus.mem_we}, 5'b10000);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    rmw("set10_3", 2'b01, 9'd10, 8'd3, 8'h00, 16'h0301, 8'h04);
    rmw("clr319_239", 2'b00, 9'd319, 8'd239, 8'hFF, 16'hEF27, 8'h7F);
    rmw("set7_0", 2'b01, 9'd7, 8'd0, 8'h00, 16'h0000, 8'h80);
    rmw("set5_1", 2'b01, 9'd5, 8'd1, 8'h0F, 16'h0100, 8'h2F);
    rmw("clr9_2", 2'b00, 9'd9, 8'd2, 8'hAA, 16'h0201, 8'hA8);
    reject("x320", 2'b01, 9'd320, 8'd0);
    reject("y240", 2'b00, 9'd0, 8'd240);
`ifdef MLBMP_PLOT_XOR_EN
    rmw("xor0_0", 2'b10, 9'd0, 8'd0, 8'h01, 16'h0000, 8'h00);
    rmw("xor3_4", 2'b10, 9'd3, 8'd4, 8'h00, 16'h0400, 8'h08);
`else
    reject("xor_off", 2'b10, 9'd0, 8'd0);
`endif
    issue(2'b11, 9'h1FF, 8'hFF, 1'b1, 8'h00);
    n_we = 0; n_bad = 0; n_data = 0; n_re = 0;
    first_addr = 16'hFFFF; last_addr = 16'hFFFF;
    done_seen = 1'b0; done_last = 1'b0;
    for (int i = 0; i < 12000 && !done_seen; i++) begin
      @(negedge clk);
      if (bus.mem_re) n_re++;
      if (bus.mem_we) begin
        if (n_we == 0) first_addr = bus.mem_addr;
        last_addr = bus.mem_addr;
        if (bus.mem_wdata !== 8'hFF) n_data++;
        if (bus.mem_addr[7:6] != 2'b00 || bus.mem_addr[5:0] >= 6'd40 || bus.mem_addr[15:8] >= 8'd240) n_bad++;
        n_we++;
      end
      if (bus.done) begin
        done_seen = 1'b1;
        done_last = bus.mem_we && bus.mem_addr == 16'hEF27;
      end
    end
    chk("fill_done", 32'(done_seen), 1);
    chk("fill_writes", n_we, 9600);
    chk("fill_first", first_addr, 16'h0000);
    chk("fill_last", last_addr, 16'hEF27);
    chk("fill_done_last", 32'(done_last), 1);
    chk("fill_bad_addr", n_bad, 0);
    chk("fill_data", n_data, 0);
    chk("fill_reads", n_re, 0);
    @(negedge clk);
    chk("fill_idle", {bus.ready, bus.done, bus.mem_we}, 3'b100);
    issue(2'b11, 9'd0, 8'd0, 1'b0, 8'h00);
    n_we = 0; n_data = 0; n_done = 0;
    for (int i = 0; i < 200 && n_we < 100; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        last_addr = bus.mem_addr;
        if (bus.mem_wdata !== 8'h00) n_data++;
        n_we++;
      end
      if (bus.done) n_done++;
    end
    chk("cut_count", n_we, 100);
    chk("cut_addr100", last_addr, 16'h0213);
    chk("cut_data", n_data, 0);
    rst_n = 1'b0;
    #1;
    chk("cut_rst", {bus.mem_we, bus.mem_re, bus.ready, bus.done, bus.err}, 5'b00100);
    chk("cut_rst_out", {bus.mem_addr, bus.mem_wdata}, 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    n_we = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_we || bus.mem_re) n_we++;
      if (bus.done) n_done++;
    end
    chk("cut_no_done", n_done, 0);
    chk("cut_no_access", n_we, 0);
    chk("cut_ready", 32'(bus.ready), 1);
    chk("conflicts", conflicts, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlbmp_plot.md
MLBMP_PLOT -- requirements
Module: mlbmp_plot

Interface
REQ-001 SHALL have parameter SCR_W, default 320, visible pixel columns.
REQ-002 SHALL have parameter SCR_H, default 240, visible pixel rows.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  1  command request; accepted on a rising edge when req && ready.
REQ-006 SHALL have port op  input  2  command: 00 clear pixel, 01 set pixel, 10 xor pixel, 11 fill screen.
REQ-007 SHALL have port x  input  9  pixel column, sampled at accept.
REQ-008 SHALL have port y  input  8  pixel row, sampled at accept.
REQ-009 SHALL have port color  input  1  fill level for op 11; ignored otherwise.
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a command completes.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a command is rejected.
REQ-013 SHALL have port mem_addr  output  16  screen byte address.
REQ-014 SHALL have port mem_re  output  1  read strobe; data returns on mem_rdata the next cycle.
REQ-015 SHALL have port mem_rdata  input  8  screen read data.
REQ-016 SHALL have port mem_we  output  1  write strobe.
REQ-017 SHALL have port mem_wdata  output  8  screen write data.

Function
REQ-018 SHALL map a pixel to the address {y[7:0], 2'b00, x[8:3]} and to bit x[2:0] of that byte, with bit 0 as the leftmost pixel.
REQ-019 SHALL latch op, x, y and color on accept and ignore req while ready is low.
REQ-020 SHALL use the states IDLE, RD, WR, FILL and ERR.
REQ-021 SHALL move from IDLE to RD on accepting op 00, 01 or 10, and SHALL hold mem_re=1 with the pixel address in RD.
REQ-022 SHALL hold mem_we=1 in WR with the same address; mem_wdata SHALL equal mem_rdata with the target bit cleared (00), set (01) or inverted (10), and all other bits unchanged.
REQ-023 SHALL pulse done in WR and then return to IDLE; accept-to-done latency SHALL be 2 cycles and ready SHALL be high 3 cycles after accept.
REQ-024 SHALL enter ERR instead of RD or FILL when x >= SCR_W, y >= SCR_H, or op is disabled, pulse err for one cycle with no mem_re or mem_we, and then return to IDLE.
REQ-025 SHALL ignore x and y for op 11.
REQ-026 SHALL write {8{color}} in FILL to one byte per cycle, with row 0..SCR_H-1 as the outer loop and byte 0..SCR_W/8-1 as the inner loop.
REQ-027 SHALL NOT issue reads during FILL.
REQ-028 SHALL pulse done together with the final write of FILL (address {SCR_H-1, 2'b00, SCR_W/8-1}).
REQ-029 SHALL never write an address with addr[7:6] != 0, a byte index >= SCR_W/8, or a row >= SCR_H.
REQ-030 SHALL never assert mem_re and mem_we in the same cycle, and SHALL never assert done and err together.

Reset
REQ-031 SHALL on rst_n low immediately force state IDLE, ready=1, and done, err, mem_re, mem_we and the fill counters to 0.
REQ-032 SHALL force mem_addr and mem_wdata to 0 on reset.
REQ-033 SHALL abandon a fill or read-modify-write cut by reset, with no completion on release.

Configuration
REQ-034 SHALL implement op 10 (xor pixel) when macro MLBMP_PLOT_XOR_EN is defined.
REQ-035 SHALL reject op 10 through ERR when MLBMP_PLOT_XOR_EN is undefined, with no xor logic present.

Structure
REQ-036 SHALL take SCR_W and SCR_H defaults, BYTES_PER_ROW, the op encodings and the state enum from shared package mlbmp_pkg.
REQ-037 SHALL place the pixel-to-address/bit-index mapping in sub-module mlbmp_addr so the display read path can share it.

Verification
REQ-038 SHALL check: set, x=10 y=3, rdata 0x00 -> mem_re at addr 0x0301, then mem_we with wdata 0x04, and done 2 cycles after accept.
REQ-039 SHALL check: clear, x=319 y=239, rdata 0xFF -> addr 0xEF27, wdata 0x7F.
REQ-040 SHALL check: set, x=320 y=0 -> err pulse, no mem_re or mem_we, ready high again 2 cycles after accept.
REQ-041 SHALL check: xor, x=0 y=0, rdata 0x01 -> wdata 0x00 with MLBMP_PLOT_XOR_EN defined, and err with no memory access without it.
REQ-042 SHALL check: fill, color=1 -> exactly 9600 writes of 0xFF, the first at 0x0000 and the last at 0xEF27 with done, and no write to addr[7:6] != 0.
REQ-043 SHALL check: rst_n low at fill write 100 -> mem_we low immediately, no done, and ready=1 after release.
